sys_bus_arbiter: RTL

- Round-robin arbiter sharing one system-bus master port between N requesters: the PS AXI slave bridge plus on-chip sequencers, DMA or calibration engines.
- Sits between the requesters and the system-bus address decoder.
- Accepts one single-beat read or write per grant, issues one strobe downstream and waits for ack.
- Returns rdata/err to the owning requester.

---
 rtl/sys_bus_arb_pkg.sv | 31 +++
 rtl/sys_bus_arbiter_rr_arbiter.sv | 28 ++
 rtl/sys_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types and helpers for the system-bus round-robin arbiter.
// The ack watchdog is built only when SYS_BUS_ARB_TIMEOUT_EN is defined.
package sys_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int MAX_N       = 8;
    localparam int TMO_DEFAULT = 255;

    // Scan last+1, last+2, ... mod n; the nearest requester wins.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_N-1:0] req,
        input logic [2:0]       last,
        input int               n
    );
        logic [2:0] pick;
        int         k;
        pick = last;
        for (int i = n; i >= 1; i--) begin
            k = (int'(last) + i) % n;
            if (req[k]) pick = 3'(k);
        end
        return pick;
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_arbiter.sv
// Combinational N-way rotating-priority pick with index and onehot outputs.
// Reusable wherever a fair single-winner choice is needed.
module rr_arbiter
    import sys_bus_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic          any
);

    logic [MAX_N-1:0] req_pad;
    logic [2:0]       pick;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        pick           = rr_pick(req_pad, 3'(last), N);
        idx            = IW'(pick);
        any            = |req;
        onehot         = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin owner of the single system-bus master port, one beat per grant.
// SYS_BUS_ARB_TIMEOUT_EN adds an ack watchdog that ends a stuck access with err.
module sys_bus_arbiter
    import sys_bus_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      wen_i,
    input  logic [N*AW-1:0]   addr_i,
    input  logic [N*DW-1:0]   wdata_i,
    input  logic [N*DW/8-1:0] sel_i,
    output logic [N-1:0]      gnt_o,
    output logic [N-1:0]      done_o,
    output logic [DW-1:0]     rdata_o,
    output logic              err_o,
    output logic [AW-1:0]     sys_addr_o,
    output logic [DW-1:0]     sys_wdata_o,
    output logic [DW/8-1:0]   sys_sel_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [DW-1:0]     sys_rdata_i,
    input  logic              sys_err_i,
    input  logic              sys_ack_i,
    output logic              busy_o
);

    localparam int IW = $clog2(N);
    localparam int SW = DW / 8;

    state_e        state;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic          wen_q;

    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic          pick_any;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req    (req_i),
        .last   (last),
        .idx    (pick_idx),
        .onehot (pick_oh),
        .any    (pick_any)
    );

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    localparam int TCW = (TMO > 255) ? 16 : 8;
    logic [TCW-1:0] cnt;
    logic           expired;
    assign expired = (cnt == TCW'(TMO - 1));
`else
    // Without the watchdog TMO has no hardware behind it.
    if (TMO == 0) begin : g_no_tmo
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            last        <= IW'(N - 1);
            owner       <= '0;
            wen_q       <= 1'b0;
            gnt_o       <= '0;
            done_o      <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            busy_o      <= 1'b0;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            done_o    <= '0;
            sys_wen_o <= 1'b0;
            sys_ren_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_o       <= pick_oh;
                        owner       <= pick_idx;
                        wen_q       <= wen_i[pick_idx];
                        sys_wen_o   <= wen_i[pick_idx];
                        sys_ren_o   <= ~wen_i[pick_idx];
                        sys_addr_o  <= addr_i[int'(pick_idx)*AW +: AW];
                        sys_wdata_o <= wdata_i[int'(pick_idx)*DW +: DW];
                        sys_sel_o   <= sel_i[int'(pick_idx)*SW +: SW];
                        busy_o      <= 1'b1;
                        state       <= ST_ISSUE;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (sys_ack_i) begin
                        rdata_o <= wen_q ? '0 : sys_rdata_i;
                        err_o   <= sys_err_i;
                        done_o  <= gnt_o;
                        state   <= ST_DONE;
`ifdef SYS_BUS_ARB_TIMEOUT_EN
                    end else if (expired) begin
                        rdata_o <= '0;
                        err_o   <= 1'b1;
                        done_o  <= gnt_o;
                        state   <= ST_DONE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        state   <= ST_WAIT;
`else
                    end else begin
                        state   <= ST_WAIT;
`endif
                    end
                end
                ST_DONE: begin
                    last   <= owner;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
